// File: rtl/reflet_int_ctrl.sv
// Memory-mapped interrupt controller: 8 synchronized sources, enable mask, 4-level routing, ID register.
// Optional level-sensitive sources are built in when REFLET_INT_CTRL_LEVEL_EN is defined.
module reflet_int_ctrl #(
    parameter int unsigned         wordsize  = 8,
    parameter logic [wordsize-1:0] base_addr = 8'hF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    input  logic [7:0]          src,
    output logic [3:0]          ext_int
);

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_LEVEL_LO = 3'd2;
    localparam logic [2:0] REG_LEVEL_HI = 3'd3;
    localparam logic [2:0] REG_ID       = 3'd4;
    localparam logic [2:0] REG_MODE     = 3'd5;

    logic [7:0] src_p0;   // first synchronizer flop
    logic [7:0] src_p1;   // second synchronizer flop
    logic [7:0] src_p2;   // previous value for edge detection
    logic [7:0] pending;
    logic [7:0] enable;
    logic [7:0] level_lo;
    logic [7:0] level_hi;
`ifdef REFLET_INT_CTRL_LEVEL_EN
    logic [7:0] mode;
`endif

    logic       sel;
    logic [2:0] idx;
    logic       wr_sel;
    logic [7:0] wdata;
    logic [7:0] edge_det;
    logic [7:0] w1c_mask;
    logic [7:0] pending_nxt;
    logic [7:0] active;
    logic [7:0] rd_byte;
    logic [wordsize-1:0] rd_word;

    function automatic logic [1:0] src_level(input logic [7:0] lo, input logic [7:0] hi,
                                             input int i);
        logic [15:0] both;
        both = {hi, lo};
        return both[2*i +: 2];
    endfunction

    function automatic logic [2:0] lowest_index(input logic [7:0] vec);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) id = 3'(i);
        end
        return id;
    endfunction

    assign sel    = (addr[wordsize-1:3] == base_addr[wordsize-1:3]);
    assign idx    = addr[2:0];
    assign wr_sel = write_en & sel;
    assign wdata  = data_in[7:0];

    generate
        if (wordsize > 8) begin : g_wide
            logic unused_data_hi;
            assign unused_data_hi = ^data_in[wordsize-1:8];
        end
    endgenerate

    assign edge_det = src_p1 & ~src_p2;
    assign active   = pending & enable;

    // Set has priority over a same-cycle write-one-to-clear.
    always_comb begin
        w1c_mask    = (wr_sel && idx == REG_PENDING) ? wdata : 8'h00;
        pending_nxt = (pending & ~w1c_mask) | edge_det;
`ifdef REFLET_INT_CTRL_LEVEL_EN
        pending_nxt = (pending_nxt & ~mode) | (src_p1 & mode);
`endif
    end

    always_comb begin
        ext_int = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            if (active[i]) ext_int[src_level(level_lo, level_hi, i)] = 1'b1;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (idx)
            REG_PENDING:  rd_byte = pending;
            REG_ENABLE:   rd_byte = enable;
            REG_LEVEL_LO: rd_byte = level_lo;
            REG_LEVEL_HI: rd_byte = level_hi;
            REG_ID:       rd_byte = {|active, 4'b0000, lowest_index(active)};
`ifdef REFLET_INT_CTRL_LEVEL_EN
            REG_MODE:     rd_byte = mode;
`endif
            default:      rd_byte = 8'h00;
        endcase
        rd_word      = '0;
        rd_word[7:0] = rd_byte;
    end

    // Synchronizer / edge-detect stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_p0 <= 8'h00;
            src_p1 <= 8'h00;
            src_p2 <= 8'h00;
        end else begin
            src_p0 <= src;
            src_p1 <= src_p0;
            src_p2 <= src_p1;
        end
    end

    // Register file and read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 8'h00;
            enable   <= 8'h00;
            level_lo <= 8'h00;
            level_hi <= 8'h00;
            data_out <= '0;
        end else begin
            pending  <= pending_nxt;
            data_out <= sel ? rd_word : '0;
            if (wr_sel) begin
                case (idx)
                    REG_ENABLE:   enable   <= wdata;
                    REG_LEVEL_LO: level_lo <= wdata;
                    REG_LEVEL_HI: level_hi <= wdata;
                    default:      ;
                endcase
            end
        end
    end

`ifdef REFLET_INT_CTRL_LEVEL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= 8'h00;
        end else if (wr_sel && idx == REG_MODE) begin
            mode <= wdata;
        end
    end
`endif

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Directed bench for reflet_int_ctrl: table-driven register checks plus hand-written event sequences.
module tb_reflet_int_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       write_en = 1'b0;
    logic [7:0] data_out;
    logic [7:0] src = 8'h00;
    logic [3:0] ext_int;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic [3:0] exp_int;
    } vec_t;

    vec_t vecs[$];

    reflet_int_ctrl #(.wordsize(8), .base_addr(8'hF0)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
        .write_en(write_en), .data_out(data_out), .src(src), .ext_int(ext_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] r, input logic [7:0] d);
        addr = {5'b11110, r};
        data_in = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic reg_read(input logic [2:0] r, output logic [7:0] d);
        addr = {5'b11110, r};
        write_en = 1'b0;
        tick();
        d = data_out;
    endtask

    logic [7:0] rd;

    initial begin
        for (int r = 0; r < 8; r++) vecs.push_back('{1'b0, 8'hF0 + 8'(r), 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF1, 8'h5A, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF1, 8'h00, 8'h5A, 4'h0});
        vecs.push_back('{1'b1, 8'hF2, 8'hE4, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF2, 8'h00, 8'hE4, 4'h0});
        vecs.push_back('{1'b1, 8'hF3, 8'h1B, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF3, 8'h00, 8'h1B, 4'h0});
        vecs.push_back('{1'b0, 8'hE9, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF9, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF6, 8'hFF, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF6, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF4, 8'hFF, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF4, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF5, 8'hFF, 8'h00, 4'h0});
`ifdef REFLET_INT_CTRL_LEVEL_EN
        vecs.push_back('{1'b0, 8'hF5, 8'h00, 8'hFF, 4'h0});
`else
        vecs.push_back('{1'b0, 8'hF5, 8'h00, 8'h00, 4'h0});
`endif
        vecs.push_back('{1'b1, 8'hF5, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF1, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF2, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b1, 8'hF3, 8'h00, 8'h00, 4'h0});
        vecs.push_back('{1'b0, 8'hF1, 8'h00, 8'h00, 4'h0});

        // reset state
        tick();
        tick();
        check("reset_ext_int", 32'(ext_int), 32'h0);
        check("reset_data_out", 32'(data_out), 32'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            addr = vecs[k].a;
            data_in = vecs[k].wdata;
            write_en = vecs[k].wr;
            tick();
            write_en = 1'b0;
            if (!vecs[k].wr) check($sformatf("vec%0d_rd", k), 32'(data_out), 32'(vecs[k].exp_rd));
            check($sformatf("vec%0d_int", k), 32'(ext_int), 32'(vecs[k].exp_int));
        end

        // src[0] pulse: two-cycle latency, ID, W1C, second pulse
        reg_write(3'd1, 8'h01);
        reg_write(3'd2, 8'h00);
        src[0] = 1'b1;
        tick(); check("lat_edge1", 32'(ext_int), 32'h0);
        tick(); check("lat_edge2", 32'(ext_int), 32'h0);
        tick(); check("lat_edge3", 32'(ext_int), 32'h1);
        tick();
        tick();
        src[0] = 1'b0;
        reg_read(3'd4, rd); check("id_src0", 32'(rd), 32'h80);
        reg_write(3'd0, 8'h01); check("w1c_src0_int", 32'(ext_int), 32'h0);
        tick();
        tick(); check("no_reedge", 32'(ext_int), 32'h0);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        tick();
        tick(); check("second_pulse", 32'(ext_int), 32'h1);
        reg_write(3'd0, 8'h01);

        // masked source 5, then enable and route to level 3
        reg_write(3'd1, 8'h00);
        src[5] = 1'b1;
        tick();
        src[5] = 1'b0;
        tick(); tick(); tick();
        reg_read(3'd0, rd); check("pend_masked", 32'(rd), 32'h20);
        check("int_masked", 32'(ext_int), 32'h0);
        reg_write(3'd1, 8'h20); check("int_en5_lvl0", 32'(ext_int), 32'h1);
        reg_write(3'd3, 8'h0C); check("int_en5_lvl3", 32'(ext_int), 32'h8);
        reg_read(3'd4, rd); check("id_src5", 32'(rd), 32'h85);
        reg_write(3'd0, 8'h20); check("w1c_src5", 32'(ext_int), 32'h0);

        // priority between sources 3 and 6
        reg_write(3'd1, 8'h48);
        src = 8'h48;
        tick();
        src = 8'h00;
        tick(); tick(); tick();
        check("int_3_6", 32'(ext_int), 32'h1);
        reg_read(3'd4, rd); check("id_3_6", 32'(rd), 32'h83);
        reg_write(3'd0, 8'h08);
        reg_read(3'd4, rd); check("id_6", 32'(rd), 32'h86);
        reg_write(3'd0, 8'h40); check("int_clear_6", 32'(ext_int), 32'h0);

        // W1C on the same edge that sets pending[2]
        src[2] = 1'b1;
        tick();
        tick();
        reg_write(3'd0, 8'h04);
        reg_read(3'd0, rd); check("set_beats_w1c", 32'(rd), 32'h04);
        reg_write(3'd0, 8'h04);
        reg_read(3'd0, rd); check("w1c_plain", 32'(rd), 32'h00);
        src[2] = 1'b0;

        // asynchronous reset while pending
        reg_write(3'd1, 8'h01);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        tick(); tick();
        check("pre_reset_int", 32'(ext_int), 32'h1);
        reg_read(3'd1, rd); check("pre_reset_en", 32'(rd), 32'h01);
        #2 reset = 1'b1;
        src[1] = 1'b1;
        #1;
        check("async_reset_int", 32'(ext_int), 32'h0);
        check("async_reset_dout", 32'(data_out), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        reg_read(3'd0, rd); check("held_src_one_edge", 32'(rd), 32'h02);
        reg_read(3'd1, rd); check("reset_enable", 32'(rd), 32'h00);
        reg_write(3'd0, 8'h02);
        tick(); tick(); tick();
        reg_read(3'd0, rd); check("held_no_recapture", 32'(rd), 32'h00);

`ifdef REFLET_INT_CTRL_LEVEL_EN
        reg_write(3'd1, 8'h02);
        reg_write(3'd5, 8'h02);
        tick(); tick(); tick();
        reg_read(3'd0, rd); check("lvl_pending", 32'(rd), 32'h02);
        reg_write(3'd0, 8'h02);
        reg_read(3'd0, rd); check("lvl_w1c_no_effect", 32'(rd), 32'h02);
        src[1] = 1'b0;
        tick(); check("lvl_drop1", 32'(ext_int), 32'h1);
        tick(); check("lvl_drop2", 32'(ext_int), 32'h1);
        tick(); check("lvl_drop3", 32'(ext_int), 32'h0);
`else
        src[1] = 1'b0;
        reg_write(3'd5, 8'hFF);
        reg_read(3'd5, rd); check("mode_reads_zero", 32'(rd), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reflet_int_ctrl.md
# reflet_int_ctrl

- Memory-mapped interrupt controller between up to 8 peripheral interrupt sources and the 4-line `ext_int` input of `reflet_cpu`.
- Captures source events with synchronization, edge detection and latching.
- Applies a per-source enable mask and routes each source to one of the 4 CPU interrupt levels, with a lowest-index-first ID register for the handler.
- Sits on the CPU data bus beside ROM/RAM and is OR-muxed into the CPU `data_in`.

## Interface
Parameters:
- `wordsize`, 8 — CPU bus width; must be ≥ 8. Register data uses bits [7:0]; upper bits read 0.
- `base_addr`, `8'hF0` — base of the 8-word register window; must be 8-aligned.

Ports:
- `clk` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — asynchronous, active-high.
- `addr` in `wordsize` — CPU address.
- `data_in` in `wordsize` — CPU write data (CPU `data_out`).
- `write_en` in 1 — CPU write strobe.
- `data_out` out `wordsize` — registered read data; 0 when not selected.
- `src` in 8 — asynchronous interrupt sources from peripherals.
- `ext_int` out 4 — to CPU `ext_int`.

## Operation
Select and registers:
- Select = `addr[wordsize-1:3] == base_addr[wordsize-1:3]`; register index = `addr[2:0]`.
- 0 PENDING: read pending[7:0]; write 1 clears that bit (W1C).
- 1 ENABLE: read/write mask.
- 2 LEVEL_LO: read/write; bits [2i+1:2i] give the CPU level of source i, i = 0..3.
- 3 LEVEL_HI: read/write; same encoding for sources 4..7.
- 4 ID: read only, `{found, 4'b0, id[2:0]}`.
  - found = |(pending & enable).
  - id = lowest index with pending & enable; 0 when found = 0.
- 5 MODE: see Configuration.
- 6, 7: read 0; writes ignored.

Event capture:
- Each `src[i]` passes through a two-flop synchronizer, then a `prev` flop.
- Rising edge = sync2 & !prev; it sets pending[i].
- Pending is latched regardless of ENABLE; masking affects only `ext_int` and ID.
- Set and W1C clear on the same bit in the same cycle: set wins.

Routing:
- `ext_int[l]` = OR over i of (pending[i] & enable[i] & level(i) == l).
- Combinational from registers; no glitch path from `src`.

Reset:
- pending, enable, levels, mode, synchronizers, prev and `data_out` all 0, so `ext_int` = 0.
- Reset asserted mid-operation discards all pending events immediately.
- A source held high through reset release is captured as one edge (prev resets to 0).

## Timing
- `src` high before edge k: sync1 at k, sync2 at k+1, pending set at k+2. `ext_int` is high from just after k+2, i.e. 2-cycle latency plus setup.
- Minimum capturable pulse width: 1 `clk` period. Pulses narrower than that may be missed.
- Read: address valid at edge n → `data_out` valid after edge n+1, matching the ROM read timing.
- Write: takes effect at the edge where `write_en` and select are sampled. `ext_int` updates the same cycle.
- W1C of a source whose new edge arrives that cycle leaves pending = 1.
- Reading ID returns state as of edge n, i.e. before any same-edge set.

## Configuration
- `REFLET_INT_CTRL_LEVEL_EN` defined:
  - MODE (reg 5) is read/write; bit i = 1 makes source i level-sensitive.
  - A level-sensitive source sets pending[i] = sync2[i] every cycle, bypassing edge detection.
  - W1C has no lasting effect on it while its input stays high.
- Undefined:
  - MODE reads 0, writes are ignored, and all sources are edge-triggered.
  - The MODE flops are not synthesized.

## Test plan
- Reset, then read regs 0–7 → all 0, `ext_int` = 0.
- Write ENABLE = 0x01, LEVEL_LO = 0x00; pulse `src[0]` for 5 cycles → `ext_int` = 4'b0001 two cycles after the rising edge; ID reads 0x80; W1C 0x01 → `ext_int` = 0 next cycle; a second pulse re-asserts it.
- ENABLE = 0x00, pulse `src[5]` → PENDING = 0x20 and `ext_int` = 0. Then write ENABLE = 0x20, LEVEL_HI = 0x0C → `ext_int` = 4'b1000; ID = 0x85.
- Pending on sources 3 and 6, both enabled → ID = 0x83. After W1C 0x08 → ID = 0x86.
- W1C on bit 2 in the same cycle as the `src[2]` edge reaches pending → PENDING bit 2 stays 1. Reset asserted mid-pending → PENDING = 0 and `ext_int` = 0 asynchronously.
- With `REFLET_INT_CTRL_LEVEL_EN`: MODE = 0x02, hold `src[1]` high → W1C does not clear bit 1; drop `src[1]` → pending clears 2 cycles later. Without the macro: MODE write 0xFF reads back 0.
